// File: rtl/apb_master_bridge_if.sv
// Request/response handshake and APB requester-side bus for apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface apb_master_bridge_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NO_OF_SLAVES  = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_error;
    logic                     rsp_timeout;

    logic [NO_OF_SLAVES-1:0]  PSELx;
    logic                     PENABLE;
    logic [ADDRESS_WIDTH-1:0] PADDR;
    logic                     PWRITE;
    logic [DATA_WIDTH-1:0]    PWDATA;
    logic [DATA_WIDTH-1:0]    PRDATA [NO_OF_SLAVES-1:0];
    logic [NO_OF_SLAVES-1:0]  PREADY;
    logic [NO_OF_SLAVES-1:0]  PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        output PSELx, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        input  PSELx, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: one outstanding valid/ready request becomes an APB SETUP/ACCESS transfer
// with slave decode, wait-state timeout and a response held until consumed.
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int NO_OF_SLAVES   = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    apb_master_bridge_if.master bus
);
    localparam int IDX_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [NO_OF_SLAVES-1:0] SEL_ONE = NO_OF_SLAVES'(1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         wait_cnt_q, wait_cnt_d;
    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_error_q, rsp_error_d;
    logic                     rsp_timeout_q, rsp_timeout_d;
    logic [NO_OF_SLAVES-1:0]  psel_q, psel_d;
    logic                     penable_q, penable_d;
    logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
    logic                     pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]    pwdata_q, pwdata_d;

    logic [IDX_W-1:0]         req_idx;
    logic                     decode_err;
    logic                     pready_sel;
    logic                     pslverr_sel;
    logic [DATA_WIDTH-1:0]    prdata_sel;

    assign req_idx     = bus.req_addr[SEL_LSB +: IDX_W];
    assign decode_err  = 32'(req_idx) >= 32'(NO_OF_SLAVES);
    assign pready_sel  = bus.PREADY[idx_q];
    assign pslverr_sel = bus.PSLVERR[idx_q];
    assign prdata_sel  = bus.PRDATA[idx_q];

    always_comb begin
        // NOTE: every _d starts from its _q so no branch leaves a signal unassigned (no latches).
        state_d       = state_q;
        idx_d         = idx_q;
        wait_cnt_d    = wait_cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    if (decode_err) begin
                        // Unmapped slave: answer immediately without touching the bus.
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end else begin
                        state_d  = SETUP;
                        idx_d    = req_idx;
                        psel_d   = SEL_ONE << req_idx;
                        paddr_d  = bus.req_addr;
                        pwrite_d = bus.req_write;
                        pwdata_d = bus.req_write ? bus.req_wdata : '0;
                    end
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                if (pready_sel) begin
                    state_d       = RESP;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    wait_cnt_d    = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = pslverr_sel;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !pslverr_sel) ? prdata_sel : '0;
                end else if (TIMEOUT_CYCLES != 0 && wait_cnt_q == CNT_LAST) begin
                    state_d       = RESP;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    wait_cnt_d    = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        // NOTE: reset clears every output flop (req_ready too) so the bus is idle the next cycle.
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            wait_cnt_q    <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wait_cnt_q    <= wait_cnt_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.PSELx       = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;
endmodule
